// File: rtl/demux_pkg.sv
// Shared types and header-field constants for the packet demultiplexer.
package demux_pkg;

  localparam int unsigned DEF_WIDTH = 128;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DEST_BIT  = 0;
  localparam int unsigned LEN_LSB   = 16;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } demux_state_t;

endpackage

// File: rtl/demux_leg_fifo.sv
// Small circular FIFO feeding one output leg; head is zero while empty.
module demux_leg_fifo
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] count;

  // Pointer and occupancy tracking; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are don't-care until the count covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  assign empty    = (count == '0);
  assign full     = (count == FCNT_W'(DEPTH));
  assign data_out = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/demux_pipe.sv
// Packet-aware splitter: routes each header and its body beats to the out or forward leg.
module demux_pipe
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_enq_ena,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq_rdy,
  output logic             out_enq_ena,
  output logic [WIDTH-1:0] out_enq_v,
  input  logic             out_enq_rdy,
  output logic             forward_enq_ena,
  output logic [WIDTH-1:0] forward_enq_v,
  input  logic             forward_enq_rdy,
  output logic [CNT_W-1:0] pkt_count_out,
  output logic [CNT_W-1:0] pkt_count_fwd
);

  demux_state_t     state;
  demux_state_t     state_nx;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] rem_nx;
  logic             sel;
  logic             sel_nx;

  logic             full_out;
  logic             full_fwd;
  logic             empty_out;
  logic             empty_fwd;
  logic             accept;
  logic             hdr_accept;
  logic             dest_now;
  logic             push_out;
  logic             push_fwd;

  logic             hdr_dest;
  logic [LEN_W-1:0] hdr_len;

  assign hdr_dest = in_enq_v[DEST_BIT];
  assign hdr_len  = in_enq_v[LEN_LSB +: LEN_W];

  // FSM state, remaining body-beat count and selected leg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HEAD;
      rem   <= '0;
      sel   <= 1'b0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      sel   <= sel_nx;
    end
  end

  // Next-state, input readiness and push steering; readiness never looks at the beat value.
  always_comb begin
    state_nx   = state;
    rem_nx     = rem;
    sel_nx     = sel;
    in_enq_rdy = 1'b0;
    accept     = 1'b0;
    hdr_accept = 1'b0;
    dest_now   = sel;
    unique case (state)
      HEAD: begin
        in_enq_rdy = !full_out && !full_fwd;
        accept     = in_enq_ena && in_enq_rdy;
        hdr_accept = accept;
        dest_now   = hdr_dest;
        if (accept && (hdr_len != '0)) begin
          state_nx = BODY;
          rem_nx   = hdr_len;
          sel_nx   = hdr_dest;
        end
      end
      BODY: begin
        in_enq_rdy = sel ? !full_fwd : !full_out;
        accept     = in_enq_ena && in_enq_rdy;
        if (accept) begin
          rem_nx = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state_nx = HEAD;
        end
      end
      default: begin
        state_nx = HEAD;
      end
    endcase
    push_out = accept && !dest_now;
    push_fwd = accept && dest_now;
  end

  // Per-leg packet counters, bumped on every accepted header.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_out <= '0;
      pkt_count_fwd <= '0;
    end else if (hdr_accept) begin
      if (hdr_dest) pkt_count_fwd <= pkt_count_fwd + CNT_W'(1);
      else          pkt_count_out <= pkt_count_out + CNT_W'(1);
    end
  end

  assign out_enq_ena     = !empty_out && out_enq_rdy;
  assign forward_enq_ena = !empty_fwd && forward_enq_rdy;

  demux_leg_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_out (
    .clk      (clk),
    .rst      (rst),
    .push     (push_out),
    .data_in  (in_enq_v),
    .pop      (out_enq_ena),
    .data_out (out_enq_v),
    .empty    (empty_out),
    .full     (full_out)
  );

  demux_leg_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_fwd (
    .clk      (clk),
    .rst      (rst),
    .push     (push_fwd),
    .data_in  (in_enq_v),
    .pop      (forward_enq_ena),
    .data_out (forward_enq_v),
    .empty    (empty_fwd),
    .full     (full_fwd)
  );

endmodule
